// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: grants the SDRAM port to cart download, backup RAM or ROM on sync slots.
// Define SDRAM_ARB_ROUND_ROBIN_EN to alternate bk/rom when both are pending; dl always wins.
module sdram_port_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        sync,
  input  logic        dl_req,
  input  logic [23:0] dl_addr,
  input  logic [15:0] dl_din,
  output logic        dl_ack,
  input  logic        rom_req,
  input  logic [23:0] rom_addr,
  input  logic [1:0]  rom_ds,
  output logic        rom_ack,
  input  logic        bk_req,
  input  logic        bk_we,
  input  logic [23:0] bk_addr,
  input  logic [15:0] bk_din,
  input  logic [1:0]  bk_ds,
  output logic        bk_ack,
  output logic [15:0] rd_data,
  output logic [23:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_ds,
  output logic        sd_we,
  output logic        sd_oe,
  input  logic [15:0] sd_dout
);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {SRC_DL, SRC_BK, SRC_ROM} src_t;
  state_t state, state_nx;
  src_t src, src_nx;
  logic [3:0] cnt;
  logic we_q, grant, done, pick_bk;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // rr_bk=1 means bk wins the next bk/rom tie; reset favours rom
  logic rr_bk;
  always_ff @(posedge clk_sys)
    if (!reset_n) rr_bk <= 1'b0;
    else if (grant && src_nx != SRC_DL) rr_bk <= src_nx == SRC_ROM;
  assign pick_bk = bk_req && (!rom_req || rr_bk);
`else
  assign pick_bk = bk_req;
`endif
  always_comb begin
    grant = state == IDLE && sync && (dl_req || bk_req || rom_req);
    done = state == BUSY && sync && cnt == 4'd1;
    src_nx = dl_req ? SRC_DL : pick_bk ? SRC_BK : SRC_ROM;
    state_nx = grant ? BUSY : done ? IDLE : state;
    sd_we = state == BUSY && we_q;
    sd_oe = state == BUSY && !we_q;
  end
  always_ff @(posedge clk_sys) state <= !reset_n ? IDLE : state_nx;
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      src <= SRC_DL;
      cnt <= 4'd0;
      we_q <= 1'b0;
      sd_addr <= 24'd0;
      sd_din <= 16'd0;
      sd_ds <= 2'b00;
      rd_data <= 16'd0;
      dl_ack <= 1'b0;
      bk_ack <= 1'b0;
      rom_ack <= 1'b0;
    end else begin
      dl_ack <= done && src == SRC_DL;
      bk_ack <= done && src == SRC_BK;
      rom_ack <= done && src == SRC_ROM;
      if (done && !we_q) rd_data <= sd_dout;
      if (grant) begin
        src <= src_nx;
        cnt <= 4'(LATENCY);
        sd_addr <= src_nx == SRC_DL ? dl_addr : src_nx == SRC_BK ? bk_addr : rom_addr;
        sd_din <= src_nx == SRC_DL ? dl_din : src_nx == SRC_BK ? bk_din : sd_din;
        sd_ds <= src_nx == SRC_DL ? 2'b11 : src_nx == SRC_BK ? bk_ds : rom_ds;
        we_q <= src_nx == SRC_DL ? 1'b1 : src_nx == SRC_BK ? bk_we : 1'b0;
      end else if (state == BUSY && sync) cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: table vectors, directed corner sequences and random traffic
// checked against a transaction-level model of the arbiter.
module tb_sdram_port_arbiter;
  localparam int LAT = 4;
  localparam int SP = 4;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk_sys = 1'b0, reset_n = 1'b0, sync = 1'b0;
  logic dl_req = 1'b0, rom_req = 1'b0, bk_req = 1'b0, bk_we = 1'b0;
  logic [23:0] dl_addr = '0, rom_addr = '0, bk_addr = '0;
  logic [15:0] dl_din = '0, bk_din = '0, sd_dout = '0;
  logic [1:0] rom_ds = '0, bk_ds = '0;
  logic dl_ack, rom_ack, bk_ack, sd_we, sd_oe;
  logic [15:0] rd_data, sd_din;
  logic [23:0] sd_addr;
  logic [1:0] sd_ds;
  sdram_port_arbiter #(.LATENCY(LAT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sync(sync),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ds(rom_ds), .rom_ack(rom_ack),
    .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_din(bk_din), .bk_ds(bk_ds), .bk_ack(bk_ack),
    .rd_data(rd_data), .sd_addr(sd_addr), .sd_din(sd_din), .sd_ds(sd_ds),
    .sd_we(sd_we), .sd_oe(sd_oe), .sd_dout(sd_dout)
  );
  always #5 clk_sys = ~clk_sys;
  int total = 0, bad = 0, cyc = 0;
  bit auto_drop = 1'b1;
  int ack_log[$];
  // model: at most one outstanding transaction, served after LAT sync slots
  bit m_busy = 0, m_we = 0, m_rr_bk = 0;
  int m_src = 0, m_left = 0;
  logic [23:0] m_addr = '0;
  logic [15:0] m_din = '0, m_rd = '0;
  logic [1:0] m_ds = '0;
  logic [2:0] m_ack = '0;
  typedef struct {
    int src;
    logic [23:0] addr;
    logic [15:0] din;
    logic [1:0] ds;
    bit we;
    logic [15:0] dout;
    logic [1:0] exp_ds;
    bit exp_we;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t vecs[5];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  task automatic model_edge();
    m_ack = '0;
    if (!reset_n) begin
      m_busy = 0; m_addr = '0; m_din = '0; m_rd = '0; m_ds = '0; m_rr_bk = 0;
    end else if (m_busy) begin
      if (sync) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_ack[m_src] = 1'b1;
          if (!m_we) m_rd = sd_dout;
        end
      end
    end else if (sync && (dl_req || bk_req || rom_req)) begin
      if (dl_req) m_src = 0;
      else if (bk_req && rom_req) m_src = RR ? (m_rr_bk ? 1 : 2) : 1;
      else m_src = bk_req ? 1 : 2;
      if (m_src != 0) m_rr_bk = (m_src == 2);
      m_busy = 1;
      m_left = LAT;
      case (m_src)
        0: begin m_addr = dl_addr; m_din = dl_din; m_ds = 2'b11; m_we = 1; end
        1: begin m_addr = bk_addr; m_din = bk_din; m_ds = bk_ds; m_we = bk_we; end
        default: begin m_addr = rom_addr; m_ds = rom_ds; m_we = 0; end
      endcase
    end
  endtask
  task automatic step();
    sync = (cyc % SP == 0);
    @(posedge clk_sys);
    model_edge();
    cyc++;
    #1;
    chk("sd_we", 32'(sd_we), 32'(m_busy && m_we));
    chk("sd_oe", 32'(sd_oe), 32'(m_busy && !m_we));
    chk("sd_addr", 32'(sd_addr), 32'(m_addr));
    chk("sd_din", 32'(sd_din), 32'(m_din));
    chk("sd_ds", 32'(sd_ds), 32'(m_ds));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    chk("acks", 32'({rom_ack, bk_ack, dl_ack}), 32'(m_ack));
    if (dl_ack) ack_log.push_back(0);
    if (bk_ack) ack_log.push_back(1);
    if (rom_ack) ack_log.push_back(2);
    if (auto_drop) begin
      if (dl_ack) dl_req = 0;
      if (bk_ack) bk_req = 0;
      if (rom_ack) rom_req = 0;
    end
  endtask
  task automatic run_txn(input vec_t v, input int k);
    int we_n, oe_n;
    bit got;
    we_n = 0; oe_n = 0; got = 0;
    sd_dout = v.dout;
    case (v.src)
      0: begin dl_req = 1; dl_addr = v.addr; dl_din = v.din; end
      1: begin bk_req = 1; bk_we = v.we; bk_addr = v.addr; bk_din = v.din; bk_ds = v.ds; end
      default: begin rom_req = 1; rom_addr = v.addr; rom_ds = v.ds; end
    endcase
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      we_n += int'(sd_we);
      oe_n += int'(sd_oe);
      got = v.src == 0 ? dl_ack : v.src == 1 ? bk_ack : rom_ack;
    end
    chk($sformatf("txn%0d_ack", k), 32'(got), 32'd1);
    chk($sformatf("txn%0d_addr", k), 32'(sd_addr), 32'(v.addr));
    chk($sformatf("txn%0d_ds", k), 32'(sd_ds), 32'(v.exp_ds));
    chk($sformatf("txn%0d_rd", k), 32'(rd_data), 32'(v.exp_rd));
    chk($sformatf("txn%0d_we_cycles", k), 32'(we_n), v.exp_we ? 32'(LAT * SP) : 32'd0);
    chk($sformatf("txn%0d_oe_cycles", k), 32'(oe_n), v.exp_we ? 32'd0 : 32'(LAT * SP));
    if (v.exp_we && v.src != 2) chk($sformatf("txn%0d_din", k), 32'(sd_din), 32'(v.din));
    step();
    chk($sformatf("txn%0d_ack_single", k), 32'({dl_ack, bk_ack, rom_ack}), 32'd0);
  endtask
  initial begin
    vecs[0] = '{2, 24'h000100, 16'h0000, 2'b11, 0, 16'hBEEF, 2'b11, 0, 16'hBEEF};
    vecs[1] = '{0, 24'h000010, 16'h1234, 2'b00, 1, 16'h5555, 2'b11, 1, 16'hBEEF};
    vecs[2] = '{1, 24'h000200, 16'hA5A5, 2'b01, 1, 16'h7777, 2'b01, 1, 16'hBEEF};
    vecs[3] = '{1, 24'h000200, 16'h0000, 2'b10, 0, 16'h0F0F, 2'b10, 0, 16'h0F0F};
    vecs[4] = '{2, 24'h00ABCD, 16'h0000, 2'b10, 0, 16'h1357, 2'b10, 0, 16'h1357};
    step(); step();
    chk("rst_outs", 32'({sd_we, sd_oe, dl_ack, bk_ack, rom_ack, sd_ds}), 32'd0);
    chk("rst_data", 32'({sd_addr, rd_data}) ^ 32'(sd_din), 32'd0);
    reset_n = 1;
    for (int k = 0; k < 5; k++) run_txn(vecs[k], k);
    // simultaneous requests: dl, then bk, then rom
    ack_log.delete();
    dl_req = 1; bk_req = 1; rom_req = 1; bk_we = 1; bk_ds = 2'b11;
    for (int i = 0; i < 300 && ack_log.size() < 3; i++) step();
    chk("prio_count", 32'(ack_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("prio_%0d", i), i < ack_log.size() ? 32'(ack_log[i]) : 32'hFF, 32'(i));
    for (int i = 0; i < 4; i++) step();
    // bk and rom held continuously
    ack_log.delete();
    auto_drop = 0;
    bk_req = 1; rom_req = 1;
    for (int i = 0; i < 400 && ack_log.size() < 4; i++) step();
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_%0d", i), i < ack_log.size() ? 32'(ack_log[i]) : 32'hFF, RR ? ((i % 2 == 0) ? 32'd1 : 32'd2) : 32'd1);
    bk_req = 0; rom_req = 0; auto_drop = 1;
    for (int i = 0; i < 24; i++) step();
    // reset in the middle of a bk write
    bk_req = 1; bk_we = 1; bk_addr = 24'h00CAFE; bk_din = 16'h4321; bk_ds = 2'b01;
    for (int i = 0; i < 50 && !sd_we; i++) step();
    chk("bkw_started", 32'(sd_we), 32'd1);
    step(); step(); step();
    reset_n = 0;
    step();
    chk("rst_busy_we", 32'(sd_we), 32'd0);
    step();
    bk_req = 0;
    chk("rst_busy_outs", 32'({sd_addr, sd_ds, sd_oe, bk_ack}), 32'd0);
    chk("rst_busy_din", 32'({rd_data, sd_din}), 32'd0);
    reset_n = 1;
    begin
      bit seen = 0;
      for (int i = 0; i < 30; i++) begin step(); seen |= bk_ack; end
      chk("rst_no_bk_ack", 32'(seen), 32'd0);
    end
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      sd_dout = 16'($urandom);
      reset_n = $urandom_range(0, 399) != 0;
      if (!dl_req && $urandom_range(0, 7) == 0) begin
        dl_req = 1; dl_addr = 24'($urandom); dl_din = 16'($urandom);
      end
      if (!bk_req && $urandom_range(0, 3) == 0) begin
        bk_req = 1; bk_we = 1'($urandom); bk_addr = 24'($urandom); bk_din = 16'($urandom); bk_ds = 2'($urandom);
      end
      if (!rom_req && $urandom_range(0, 3) == 0) begin
        rom_req = 1; rom_addr = 24'($urandom); rom_ds = 2'($urandom);
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter: LATENCY, default 4, sync strobes from grant to transaction completion; legal range 1..15.
REQ-002 clk_sys  in  1  system clock (64 MHz).
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 sync  in  1  slot strobe (ce_cpu2x), one clk_sys cycle wide.
REQ-005 dl_req  in  1  cart download write request.
REQ-006 dl_addr  in  24  download word address.
REQ-007 dl_din  in  16  download write data; both bytes written.
REQ-008 dl_ack  out  1  download completion pulse.
REQ-009 rom_req  in  1  MBC ROM read request.
REQ-010 rom_addr  in  24  ROM word address.
REQ-011 rom_ds  in  2  ROM byte selects.
REQ-012 rom_ack  out  1  ROM completion pulse; rd_data valid.
REQ-013 bk_req  in  1  backup-RAM request.
REQ-014 bk_we  in  1  backup-RAM write (1) or read (0).
REQ-015 bk_addr  in  24  backup-RAM word address.
REQ-016 bk_din  in  16  backup-RAM write data.
REQ-017 bk_ds  in  2  backup-RAM byte selects.
REQ-018 bk_ack  out  1  backup-RAM completion pulse.
REQ-019 rd_data  out  16  captured read data for rom or bk read.
REQ-020 sd_addr  out  24  to sdram controller addr.
REQ-021 sd_din  out  16  to sdram controller din.
REQ-022 sd_ds  out  2  to sdram controller ds.
REQ-023 sd_we  out  1  to sdram controller we.
REQ-024 sd_oe  out  1  to sdram controller oe.
REQ-025 sd_dout  in  16  from sdram controller dout.

Function
REQ-026 FSM states: IDLE, BUSY; grant only in IDLE on a clk_sys edge where sync=1 and any req=1.
REQ-027 Priority at grant: dl > bk > rom (fixed order without REQ-040 macro).
REQ-028 At grant: latch granted addr/din/ds/we into sd_*; dl forces sd_ds=2'b11, sd_we=1; rom forces sd_we=0; load 4-bit counter with LATENCY; enter BUSY.
REQ-029 In BUSY: sd_addr/sd_din/sd_ds constant; exactly one of sd_we/sd_oe high; counter decrements on each sync.
REQ-030 On sync with counter==1: reads capture sd_dout into rd_data; granted ack pulses high for exactly one clk_sys cycle, the cycle after that edge; return IDLE, sd_we=sd_oe=0.
REQ-031 Grant-to-ack latency = LATENCY sync periods (+1 clk_sys); next grant no earlier than the following sync.
REQ-032 Requester holds req and operands until its ack; a req dropped mid-BUSY still completes and acks; a req held after ack is a new request.
REQ-033 In IDLE, sd_addr/sd_din/sd_ds retain last values; rd_data holds until next read capture; writes leave rd_data unchanged.
REQ-034 At most one ack high in any cycle; no ack without prior grant.
REQ-035 Requests arriving in BUSY wait; no preemption, including by dl_req.

Reset
REQ-036 reset_n=0 at a clk_sys edge: state IDLE, counter 0, all acks 0, sd_we=sd_oe=0, sd_addr/sd_din/rd_data 0, sd_ds 2'b00, RR pointer to rom.
REQ-037 Reset during BUSY aborts the transaction; no ack is issued for it.
REQ-038 First grant after reset release requires a sync with reset_n=1.

Configuration
REQ-039 Macro SDRAM_ARB_ROUND_ROBIN_EN selects bk/rom arbitration; dl always highest.
REQ-040 Defined: bk and rom alternate when both pending (pointer toggles to the other after each bk/rom grant); undefined: bk always beats rom.

Verification
REQ-041 rom_req, rom_addr=24'h000100, sd_dout=16'hBEEF, LATENCY=4 -> sd_oe high 4 sync periods, rom_ack one cycle, rd_data=16'hBEEF.
REQ-042 dl_req, bk_req, rom_req same sync -> grant order dl, bk, rom; three single-cycle acks, never overlapping.
REQ-043 bk_req+rom_req held continuously, macro defined -> grants alternate bk,rom,bk,rom; undefined -> rom never granted.
REQ-044 reset_n low 2 cycles mid-BUSY of a bk write -> sd_we=0 next cycle, no bk_ack, outputs at reset values.
REQ-045 dl_req dl_addr=24'h000010 dl_din=16'h1234 -> sd_we=1, sd_ds=2'b11, sd_din=16'h1234 for 4 sync periods, dl_ack, rd_data unchanged.
